dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port word memory that answers one request at a time after a fixed
// wait, with byte-masked writes and range/alignment rejection.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  write_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        error_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          req;
  logic          in_idle;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [3:0]    op_we;
  logic          op_err;
  logic [AW-1:0] op_idx;
  logic          go_resp;

  assign req     = en_i | (|write_i);
  assign in_idle = (state_q == IDLE);

  // With zero latency the access happens on the accepting edge itself,
  // so the live inputs stand in for the not-yet-written latch.
  assign op_addr  = in_idle ? addr_i  : addr_q;
  assign op_wdata = in_idle ? data_i  : wdata_q;
  assign op_we    = in_idle ? write_i : we_q;
  assign op_idx   = op_addr[AW+1:2];
  assign op_err   = (op_addr[1:0] != 2'b00) |
                    ((op_addr >> (AW + 2)) != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr_i;
          wdata_d = data_i;
          we_d    = write_i;
          err_d   = op_err;
          if (LATENCY == 0) begin
            go_resp = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          go_resp = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      if (op_err) begin
        rdata_d = 32'h0;
      end else if (op_we == 4'b0000) begin
        rdata_d = mem_q[op_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 4'b0000;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (!rst_i && go_resp && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (op_we[b]) begin
          mem_q[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
        end
      end
    end
  end

  assign ack_o   = (state_q == RESP);
  assign error_o = ack_o & err_q;
  assign busy_o  = (state_q == WAIT);
  assign data_o  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances at latencies 2, 0 and 3,
// table vectors plus reset and held-request sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  en_s;
  logic [3:0]  we_s [3];
  logic [31:0] addr_s [3];
  logic [31:0] wd_s [3];
  logic [31:0] rd_w [3];
  logic [2:0]  ack_w, err_w, busy_w;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ee;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_i(rst), .en_i(en_s[0]),
    .addr_i(addr_s[0]), .data_i(wd_s[0]), .write_i(we_s[0]),
    .data_o(rd_w[0]), .ack_o(ack_w[0]),
    .error_o(err_w[0]), .busy_o(busy_w[0])
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_i(rst), .en_i(en_s[1]),
    .addr_i(addr_s[1]), .data_i(wd_s[1]), .write_i(we_s[1]),
    .data_o(rd_w[1]), .ack_o(ack_w[1]),
    .error_o(err_w[1]), .busy_o(busy_w[1])
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_i(rst), .en_i(en_s[2]),
    .addr_i(addr_s[2]), .data_i(wd_s[2]), .write_i(we_s[2]),
    .data_o(rd_w[2]), .ack_o(ack_w[2]),
    .error_o(err_w[2]), .busy_o(busy_w[2])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input int k, input int lat,
                          input bit garble, input string nm);
    bit   got = 0;
    exp_t x;
    for (int n = 1; n <= lat + 4 && !got; n++) begin
      @(negedge clk);
      if (ack_w[k]) begin
        got = 1;
        en_s[k] = 1'b0;
        we_s[k] = 4'b0000;
        chk({nm, ":lat"}, 32'(n), 32'(lat + 1));
        chk({nm, ":busy_resp"}, {31'b0, busy_w[k]}, 0);
        if (sb.size() == 0) begin
          chk({nm, ":sb_empty"}, 1, 0);
        end else begin
          x = sb.pop_front();
          chk({nm, ":data"}, rd_w[k], x.d);
          chk({nm, ":err"}, {31'b0, err_w[k]}, {31'b0, x.e});
        end
      end else begin
        chk({nm, ":busy_wait"}, {31'b0, busy_w[k]},
            (n <= lat) ? 1 : 0);
        chk({nm, ":err_noack"}, {31'b0, err_w[k]}, 0);
        if (garble) begin
          en_s[k]   = 1'b1;
          we_s[k]   = 4'b1111;
          addr_s[k] = 32'h0000_000C;
          wd_s[k]   = $urandom;
        end
      end
    end
    if (!got) chk({nm, ":ack_timeout"}, 0, 1);
    @(negedge clk);
    chk({nm, ":ack_pulse"}, {31'b0, ack_w[k]}, 0);
    chk({nm, ":err_after"}, {31'b0, err_w[k]}, 0);
  endtask

  task automatic txn(input int k, input int lat, input logic en,
                     input logic [3:0] we, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ed,
                     input logic ee, input string nm);
    en_s[k]   = en;
    we_s[k]   = we;
    addr_s[k] = a;
    wd_s[k]   = d;
    sb.push_back('{ed, ee});
    @(posedge clk);
    #1;
    en_s[k] = 1'b0;
    we_s[k] = 4'b0000;
    wait_ack(k, lat, 1'b0, nm);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 32'h20, 32'h11223344, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b0, 4'h5, 32'h20, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 32'h11BB33DD, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 32'h22, 32'h0, 32'h0, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 32'h1000, 32'h12345678, 32'h0, 1'b1};
    tbl[8]  = '{1'b1, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0};
    tbl[9]  = '{1'b1, 4'h0, 32'h80000010, 32'h0, 32'h0, 1'b1};
    tbl[10] = '{1'b1, 4'h3, 32'h10, 32'h00001234, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 4'h0, 32'h10, 32'h0, 32'hDEAD1234, 1'b0};
    tbl[12] = '{1'b0, 4'hF, 32'h3, 32'hFFFFFFFF, 32'h0, 1'b1};
    tbl[13] = '{1'b1, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0};
    tbl[14] = '{1'b0, 4'hF, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0};

    en_s = 3'b000;
    for (int k = 0; k < 3; k++) begin
      we_s[k]   = 4'b0000;
      addr_s[k] = 32'h0;
      wd_s[k]   = 32'h0;
    end

    // request held high throughout reset must not be taken
    en_s[0]   = 1'b1;
    addr_s[0] = 32'h22;
    repeat (3) @(negedge clk);
    chk("rst:busy", {31'b0, busy_w[0]}, 0);
    chk("rst:ack", {31'b0, ack_w[0]}, 0);
    chk("rst:err", {31'b0, err_w[0]}, 0);
    chk("rst:data", rd_w[0], 0);
    rst = 1'b0;
    sb.push_back('{32'h0, 1'b1});
    @(posedge clk);
    #1;
    en_s[0] = 1'b0;
    wait_ack(0, 2, 1'b0, "rst_first_accept");

    for (int i = 0; i < 15; i++) begin
      txn(0, 2, tbl[i].en, tbl[i].we, tbl[i].a, tbl[i].d,
          tbl[i].ed, tbl[i].ee, $sformatf("vec%0d", i));
    end

    // reset in the middle of a pending write to 0x30
    en_s[0]   = 1'b0;
    we_s[0]   = 4'hF;
    addr_s[0] = 32'h30;
    wd_s[0]   = 32'h55555555;
    @(posedge clk);
    #1;
    we_s[0] = 4'h0;
    @(negedge clk);
    chk("midrst:busy", {31'b0, busy_w[0]}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst:data", rd_w[0], 0);
    chk("midrst:busy0", {31'b0, busy_w[0]}, 0);
    for (int n = 0; n < 4; n++) begin
      chk("midrst:noack", {31'b0, ack_w[0]}, 0);
      chk("midrst:noerr", {31'b0, err_w[0]}, 0);
      @(negedge clk);
    end
    txn(0, 2, 1'b1, 4'h0, 32'h30, 32'h0, 32'h0, 1'b0,
        "midrst:readback");

    // zero latency: back-to-back write/read and held request
    txn(1, 0, 1'b0, 4'hF, 32'h4, 32'hA5A5A5A5, 32'h0, 1'b0,
        "l0:wr");
    txn(1, 0, 1'b1, 4'h0, 32'h4, 32'h0, 32'hA5A5A5A5, 1'b0,
        "l0:rd");
    txn(1, 0, 1'b0, 4'hF, 32'h40, 32'h1, 32'h0, 1'b1,
        "l0:range");
    en_s[1]   = 1'b1;
    addr_s[1] = 32'h4;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk($sformatf("l0hold:ack%0d", n), {31'b0, ack_w[1]},
          {31'b0, n[0]});
      chk($sformatf("l0hold:busy%0d", n), {31'b0, busy_w[1]}, 0);
    end
    en_s[1] = 1'b0;
    @(negedge clk);

    // latency 3: inputs scrambled while waiting must be ignored
    txn(2, 3, 1'b0, 4'hF, 32'h8, 32'h0BADCAFE, 32'h0, 1'b0,
        "l3:wr8");
    txn(2, 3, 1'b0, 4'hF, 32'hC, 32'h12121212, 32'h0, 1'b0,
        "l3:wrC");
    en_s[2]   = 1'b1;
    we_s[2]   = 4'h0;
    addr_s[2] = 32'h8;
    sb.push_back('{32'h0BADCAFE, 1'b0});
    @(posedge clk);
    wait_ack(2, 3, 1'b1, "l3:garble");
    txn(2, 3, 1'b1, 4'h0, 32'hC, 32'h0, 32'h12121212, 1'b0,
        "l3:rdC");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
